sw_debounce_irq_ctrl: RTL and testbench

Avalon-MM slave controller for the 8-bit board switch bank. It synchronises the raw switch inputs and paces debounce sampling with a prescaled tick. A settle state machine decides when the switch word is stable, then latches per-bit edge flags and raises a maskable interrupt to the Nios II. It replaces direct raw-switch reads: software reads clean, debounced values and edge history instead of polling bounce-prone pins.

---
 rtl/sw_debounce_irq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sw_debounce_irq_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_irq_ctrl.sv
// Debounced switch bank with per-bit edge flags and a maskable level interrupt,
// exposed as a four-word Avalon-MM slave.
module sw_debounce_irq_ctrl #(
    parameter int unsigned WIDTH            = 8,
    parameter int unsigned PRESCALE         = 50000,
    parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [0:0] {StStable, StSettling} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] meta_q, sync_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_flags_q, edge_flags_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [7:0]       thr_q, thr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       cnt_inc, eff_thr;
    logic [31:0]      rdata_q, rdata_d;
    logic             tick;
    logic             commit;
    logic [WIDTH-1:0] commit_val;
    logic             wr_en;
    logic [WIDTH-1:0] clr_bits;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    // Prescaler: one-cycle tick every PRESCALE clocks
    always_comb begin
        tick    = (presc_q == PW'(PRESCALE - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // A threshold of zero is treated as one; counter saturates at 255
    always_comb begin
        eff_thr = (thr_q == 8'd0) ? 8'd1 : thr_q;
        cnt_inc = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
    end

    // Settle FSM: decides when the synchronised word is accepted
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        commit     = 1'b0;
        commit_val = cand_q;
        if (tick) begin
            unique case (state_q)
                StStable: begin
                    if (sync_q != deb_q) begin
                        if (eff_thr <= 8'd1) begin
                            commit     = 1'b1;
                            commit_val = sync_q;
                        end else begin
                            cand_d  = sync_q;
                            cnt_d   = 8'd1;
                            state_d = StSettling;
                        end
                    end
                end
                StSettling: begin
                    if (sync_q == deb_q) begin
                        // Bounced back to the accepted value
                        state_d = StStable;
                    end else if (sync_q != cand_q) begin
                        cand_d = sync_q;
                        cnt_d  = 8'd1;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= eff_thr) begin
                            commit     = 1'b1;
                            commit_val = cand_q;
                            state_d    = StStable;
                        end
                    end
                end
                default: state_d = StStable;
            endcase
        end
    end

    // Register writes, commit and edge capture; a commit set beats a software clear
    always_comb begin
        wr_en        = chipselect & ~write_n;
        mask_d       = mask_q;
        thr_d        = thr_q;
        clr_bits     = '0;
        if (wr_en) begin
            unique case (address)
                2'd1:    mask_d   = writedata[WIDTH-1:0];
                2'd2:    thr_d    = writedata[7:0];
                2'd3:    clr_bits = writedata[WIDTH-1:0];
                default: ;
            endcase
        end
        edge_flags_d = edge_flags_q & ~clr_bits;
        deb_d        = deb_q;
        if (commit) begin
            edge_flags_d = edge_flags_d | (deb_q ^ commit_val);
            deb_d        = commit_val;
        end
    end

    // Read mux, registered every cycle regardless of chipselect
    always_comb begin
        rdata_d = '0;
        unique case (address)
            2'd0: rdata_d = 32'(deb_q);
            2'd1: rdata_d = 32'(mask_q);
            2'd2: rdata_d = {(state_q == StSettling), 23'd0, thr_q};
            2'd3: rdata_d = 32'(edge_flags_q);
            default: ;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StStable;
            meta_q       <= '0;
            sync_q       <= '0;
            cand_q       <= '0;
            deb_q        <= '0;
            mask_q       <= '0;
            edge_flags_q <= '0;
            presc_q      <= '0;
            thr_q        <= 8'(DEBOUNCE_SAMPLES);
            cnt_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            meta_q       <= in_port;
            sync_q       <= meta_q;
            cand_q       <= cand_d;
            deb_q        <= deb_d;
            mask_q       <= mask_d;
            edge_flags_q <= edge_flags_d;
            presc_q      <= presc_d;
            thr_q        <= thr_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(edge_flags_q & mask_q);

endmodule

// File: tb/tb_sw_debounce_irq_ctrl.sv
// Scoreboard bench for sw_debounce_irq_ctrl with a run-length debounce model.
module tb_sw_debounce_irq_ctrl;

    localparam int W   = 8;
    localparam int PRE = 4;
    localparam int DEB = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   address = 2'd0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = 32'd0;
    logic [31:0]  readdata;
    logic [W-1:0] in_port = '0;
    logic         irq;

    sw_debounce_irq_ctrl #(
        .WIDTH(W),
        .PRESCALE(PRE),
        .DEBOUNCE_SAMPLES(DEB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the switch word is accepted once a run of identical
    // tick samples, differing from the accepted word, reaches the threshold.
    typedef struct packed {
        logic [W-1:0] s1;
        logic [W-1:0] sync;
        logic [W-1:0] deb;
        logic [W-1:0] mask;
        logic [W-1:0] edg;
        logic [W-1:0] run_val;
        int           presc;
        int           run_len;
        logic [7:0]   thr;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.thr = 8'(DEB);
        return r;
    endfunction

    function automatic int eff_of(input model_t s);
        return (s.thr == 8'd0) ? 1 : int'(s.thr);
    endfunction

    function automatic model_t model_step(input model_t s, input logic wr, input logic [1:0] a,
                                          input logic [31:0] wd, input logic [W-1:0] pin);
        model_t       n;
        logic         commit;
        logic [W-1:0] val;
        logic [W-1:0] clr;
        int           eff;
        n = s;
        commit = 1'b0;
        val = '0;
        clr = '0;
        eff = eff_of(s);
        if (s.presc == PRE - 1) begin
            n.presc = 0;
            if (s.sync == s.deb) begin
                n.run_len = 0;
            end else if (s.run_len == 0) begin
                if (eff <= 1) begin
                    commit = 1'b1;
                    val = s.sync;
                end else begin
                    n.run_val = s.sync;
                    n.run_len = 1;
                end
            end else if (s.sync != s.run_val) begin
                // A new run begun mid-settle never commits on its first sample
                n.run_val = s.sync;
                n.run_len = 1;
            end else begin
                n.run_len = (s.run_len >= 255) ? 255 : s.run_len + 1;
                if (n.run_len >= eff) begin
                    commit = 1'b1;
                    val = s.run_val;
                    n.run_len = 0;
                end
            end
        end else begin
            n.presc = s.presc + 1;
        end
        if (wr && a == 2'd1) n.mask = wd[W-1:0];
        if (wr && a == 2'd2) n.thr = wd[7:0];
        if (wr && a == 2'd3) clr = wd[W-1:0];
        n.edg = s.edg & ~clr;
        if (commit) begin
            n.edg = n.edg | (s.deb ^ val);
            n.deb = val;
        end
        n.sync = s.s1;
        n.s1 = pin;
        return n;
    endfunction

    function automatic logic [31:0] exp_read(input model_t s, input logic [1:0] a);
        case (a)
            2'd0:    return 32'(s.deb);
            2'd1:    return 32'(s.mask);
            2'd2:    return {(s.run_len != 0), 23'd0, s.thr};
            default: return 32'(s.edg);
        endcase
    endfunction

    // True when the coming clock edge commits a new debounced value
    function automatic logic commit_next(input model_t s);
        int eff;
        eff = eff_of(s);
        if (s.presc != PRE - 1 || s.sync == s.deb) return 1'b0;
        if (s.run_len == 0) return (eff <= 1);
        return (s.sync == s.run_val) && (s.run_len + 1 >= eff);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= model_reset();
        else       m <= model_step(m, chipselect && !write_n, address, writedata, in_port);
    end

    // Scoreboard
    int          due_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Monitor: irq is live every cycle; readdata is due one cycle after its address
    always @(negedge clk) begin
        if (!reset) begin
            check("irq", 32'(irq), 32'(|(m.edg & m.mask)));
            while (due_q.size() > 0 && due_q[0] < cyc) begin
                timeout_fail({"missed read ", name_q[0]});
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
                void'(name_q.pop_front());
            end
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                check(name_q[0], readdata, exp_q[0]);
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
                void'(name_q.pop_front());
            end
        end
    end

    // All stimulus helpers start and end 1 time unit after a rising edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic bus_read_exp(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        due_q.push_back(cyc + 1);
        exp_q.push_back(exp);
        name_q.push_back(name);
        step(1);
    endtask

    task automatic bus_read(input logic [1:0] a, input string name);
        bus_read_exp(a, exp_read(m, a), name);
    endtask

    task automatic wait_busy(input logic want, input string name);
        int n;
        n = 0;
        while (((m.run_len != 0) != want) && n < 40) begin
            step(1);
            n++;
        end
        if (n >= 40) timeout_fail(name);
    endtask

    task automatic wait_deb(input logic [W-1:0] v, input string name);
        int n;
        n = 0;
        while (m.deb != v && n < 60) begin
            step(1);
            n++;
        end
        if (n >= 60) timeout_fail(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int op;
        logic [W-1:0] one;
        one = 1;

        // 1. Reset values
        step(3);
        reset = 1'b0;
        bus_read_exp(2'd2, 32'h0000_0003, "reset thr");
        bus_read_exp(2'd0, 32'h0000_0000, "reset deb");

        // 2. Accept 0x05 with mask clear
        in_port = 8'h05;
        wait_busy(1'b1, "busy 0x05");
        bus_read(2'd2, "busy bit");
        wait_deb(8'h05, "commit 0x05");
        bus_read_exp(2'd0, 32'h0000_0005, "deb 0x05");
        bus_read_exp(2'd3, 32'h0000_0005, "edge 0x05");

        // 3. Masked interrupt and clear
        bus_write(2'd1, 32'h0000_0001);
        in_port = 8'h04;
        wait_deb(8'h04, "commit 0x04");
        step(2);
        bus_write(2'd3, 32'h0000_0001);
        bus_read_exp(2'd3, 32'h0000_0004, "edge after clear");

        // 4. Bounce returns to old value
        in_port = 8'h00;
        wait_deb(8'h00, "commit 0x00");
        bus_write(2'd3, 32'h0000_00FF);
        bus_write(2'd1, 32'h0000_00FF);
        in_port = 8'h80;
        wait_busy(1'b1, "busy bounce");
        in_port = 8'h00;
        wait_busy(1'b0, "bounce settle");
        bus_read_exp(2'd0, 32'h0000_0000, "bounce deb");
        bus_read_exp(2'd3, 32'h0000_0000, "bounce edge");
        bus_read_exp(2'd2, 32'h0000_0003, "bounce busy clr");

        // 5. Threshold 0 commits on first tick
        bus_write(2'd2, 32'h0000_0000);
        in_port = 8'hFF;
        wait_deb(8'hFF, "commit 0xFF");
        bus_read_exp(2'd3, 32'h0000_00FF, "thr0 edge");
        bus_read_exp(2'd2, 32'h0000_0000, "thr0 busy");

        // 6. Commit set beats same-cycle software clear
        bus_write(2'd2, 32'h0000_0003);
        bus_write(2'd3, 32'h0000_00FF);
        in_port = 8'hFB;
        begin
            int n;
            n = 0;
            while (!commit_next(m) && n < 60) begin
                step(1);
                n++;
            end
            if (n >= 60) timeout_fail("commit align");
        end
        bus_write(2'd3, 32'h0000_0004);
        bus_read_exp(2'd3, 32'h0000_0004, "set wins");

        // Reset mid-settle clears everything immediately
        in_port = 8'hFF;
        wait_busy(1'b1, "busy before reset");
        #2;
        reset = 1'b1;
        #1;
        check("async rst readdata", readdata, 32'h0);
        check("async rst irq", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_read_exp(2'd2, 32'h0000_0003, "post rst thr");
        bus_read_exp(2'd0, 32'h0000_0000, "post rst deb");
        bus_read_exp(2'd1, 32'h0000_0000, "post rst mask");
        bus_read_exp(2'd3, 32'h0000_0000, "post rst edge");

        // Randomised traffic against the model
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 9));
            if (op < 3) begin
                in_port = in_port ^ (one << $urandom_range(0, W - 1));
                step(int'($urandom_range(1, 16)));
            end else if (op < 5) begin
                in_port = W'($urandom);
                step(int'($urandom_range(1, 16)));
            end else if (op == 5) begin
                bus_write(2'd1, $urandom);
            end else if (op == 6) begin
                bus_write(2'd2, 32'($urandom_range(0, 4)));
            end else if (op == 7) begin
                bus_write(2'd3, $urandom);
            end else begin
                bus_read(2'($urandom_range(0, 3)), "rand read");
            end
        end
        step(3);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
